// File: rtl/qoa_spi_pkg.sv
// Shared types and defaults for the QOA SPI mode-0 master.
// Optional byte gap selected by QOA_SPI_BYTE_GAP_EN.
package qoa_spi_pkg;

  localparam int BYTE_W       = 8;
  localparam int WAIT_W       = 16;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_BYTE_GAP = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_BYTE_DONE,
    ST_CS_HOLD
  } spi_state_t;

endpackage

// File: rtl/qoa_spi_shift8.sv
// 8-bit TX/RX shift pair with a 3-bit bit counter, strobed by the FSM.
// Counter only returns to 7 on a new load, never by wrapping.
module qoa_spi_shift8
  import qoa_spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              shift,
  input  logic              sample,
  input  logic              miso,
  output logic              mosi,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              last_bit
);

  logic [BYTE_W-1:0] tx_sr;
  logic [BYTE_W-1:0] rx_sr;
  logic [2:0]        bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= 3'd7;
    end else begin
      if (load) begin
        tx_sr   <= load_data;
        bit_cnt <= 3'd7;
      end else if (shift) begin
        tx_sr <= {tx_sr[BYTE_W-2:0], 1'b0};
        if (bit_cnt != 3'd0)
          bit_cnt <= bit_cnt - 3'd1;
      end
      if (sample)
        rx_sr <= {rx_sr[BYTE_W-2:0], miso};
    end
  end

  assign mosi     = tx_sr[BYTE_W-1];
  assign rx_byte  = rx_sr;
  assign last_bit = (bit_cnt == 3'd0);

endmodule

// File: rtl/qoa_spi_master.sv
// SPI mode-0 master streaming bytes to the QOA decoder slave port.
// Define QOA_SPI_BYTE_GAP_EN to idle BYTE_GAP clks between bytes.
module qoa_spi_master
  import qoa_spi_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int BYTE_GAP = DEF_BYTE_GAP
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [BYTE_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int DIV_W = $clog2(CLK_DIV);

  spi_state_t        state;
  spi_state_t        state_nx;
  logic [DIV_W-1:0]  div_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              armed;
  logic              last_q;
  logic              div_done;
  logic              wait_done;
  logic              gap_ok;
  logic              accept;
  logic              sample;
  logic              shift;
  logic              last_bit;
  logic [BYTE_W-1:0] rx_byte;

  assign div_done  = (div_cnt == '0);
  assign wait_done = (wait_cnt == '0);

`ifdef QOA_SPI_BYTE_GAP_EN
  assign gap_ok = wait_done;
`else
  assign gap_ok = 1'b1;
`endif

  // armed keeps tx_ready low until the first edge after reset
  assign tx_ready = armed & ((state == ST_IDLE) |
                    ((state == ST_BYTE_DONE) & ~last_q & gap_ok));
  assign accept   = tx_valid & tx_ready;
  assign sample   = (state == ST_BIT_LOW) & div_done;
  assign shift    = (state == ST_BIT_HIGH) & div_done;

  qoa_spi_shift8 u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (tx_data),
    .shift     (shift),
    .sample    (sample),
    .miso      (miso),
    .mosi      (mosi),
    .rx_byte   (rx_byte),
    .last_bit  (last_bit)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (accept) state_nx = ST_CS_SETUP;
      ST_CS_SETUP:
        if (wait_done) state_nx = ST_BIT_LOW;
      ST_BIT_LOW:
        if (div_done) state_nx = ST_BIT_HIGH;
      ST_BIT_HIGH:
        if (div_done)
          state_nx = last_bit ? ST_BYTE_DONE : ST_BIT_LOW;
      ST_BYTE_DONE:
        if (last_q)      state_nx = ST_CS_HOLD;
        else if (accept) state_nx = ST_BIT_LOW;
      ST_CS_HOLD:
        if (wait_done) state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      armed    <= 1'b0;
      last_q   <= 1'b0;
      div_cnt  <= '0;
      wait_cnt <= '0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      if (accept)
        last_q <= tx_last;
      if (state_nx != state)
        div_cnt <= DIV_W'(CLK_DIV - 1);
      else if (!div_done)
        div_cnt <= div_cnt - DIV_W'(1);
      if (state_nx != state) begin
        case (state_nx)
          ST_CS_SETUP:  wait_cnt <= WAIT_W'(CS_SETUP - 1);
          ST_CS_HOLD:   wait_cnt <= WAIT_W'(CS_HOLD - 1);
          ST_BYTE_DONE: wait_cnt <= WAIT_W'(BYTE_GAP);
          default:      wait_cnt <= '0;
        endcase
      end else if (!wait_done) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end
      // pins registered from next state to stay glitch-free
      sclk     <= (state_nx == ST_BIT_HIGH);
      cs_n     <= (state_nx == ST_IDLE);
      busy     <= (state_nx != ST_IDLE);
      rx_valid <= (state_nx == ST_BYTE_DONE) &&
                  (state != ST_BYTE_DONE);
      if ((state_nx == ST_BYTE_DONE) && (state != ST_BYTE_DONE))
        rx_data <= rx_byte;
    end
  end

endmodule

// File: tb/tb_qoa_spi_master.sv
// Scoreboard bench for qoa_spi_master with a mode-0 slave model.
// Gap timing expectation follows QOA_SPI_BYTE_GAP_EN.
module tb_qoa_spi_master;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int BYTE_GAP = 16;
`ifdef QOA_SPI_BYTE_GAP_EN
  localparam int GAP_EXP  = BYTE_GAP;
`else
  localparam int GAP_EXP  = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       miso = 1'b0;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       cs_n;

  int n_pass = 0;
  int n_tot  = 0;
  int rise_cnt = 0;
  int rxv_cnt  = 0;
  int cs_fall_cnt = 0;
  int cs_rise_cnt = 0;

  byte unsigned exp_rx[$];
  byte unsigned exp_mosi[$];
  byte unsigned resp_q[$];

  always #5 clk = ~clk;

  qoa_spi_master #(
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD),
    .BYTE_GAP (BYTE_GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso),
    .cs_n     (cs_n)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // mode-0 slave: drives miso before each rise, captures mosi on rises
  initial begin
    logic       pc;
    logic       ps;
    logic [7:0] s_tx;
    logic [7:0] s_rx;
    int         sc;
    bit         reload;
    pc = 1'b1; ps = 1'b0; s_tx = 8'h00; s_rx = 8'h00;
    sc = 0; reload = 1'b0;
    forever begin
      @(cs_n or sclk);
      if (cs_n !== pc) begin
        if (cs_n === 1'b0) begin
          cs_fall_cnt++;
          sc = 0; reload = 1'b0;
          s_tx = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
          miso = s_tx[7];
        end else begin
          if (cs_n === 1'b1) cs_rise_cnt++;
          sc = 0; reload = 1'b0;
        end
      end
      if (sclk !== ps) begin
        if (sclk === 1'b1) begin
          rise_cnt++;
          s_rx = {s_rx[6:0], mosi};
          sc++;
          if (sc == 8) begin
            sc = 0;
            reload = 1'b1;
            if (exp_mosi.size() == 0) chk("mosi_unexpected", 1, 0);
            else chk("mosi_byte", s_rx, exp_mosi.pop_front());
          end
        end else begin
          if (reload) begin
            reload = 1'b0;
            s_tx = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
          end else begin
            s_tx = {s_tx[6:0], 1'b0};
          end
          miso = s_tx[7];
        end
      end
      pc = cs_n; ps = sclk;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        rxv_cnt++;
        if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
        else chk("rx_data", rx_data, exp_rx.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] d, input logic last,
                      input logic [7:0] resp, input bit track);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    if (track) begin
      exp_mosi.push_back(d);
      exp_rx.push_back(resp);
    end
    tx_valid = 1'b1; tx_data = d; tx_last = last;
    @(posedge clk);
    #1 tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic wait_rxv(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_valid && n < 500);
    if (!rx_valid) n = -1;
  endtask

  task automatic wait_cs_high(output int m);
    m = 0;
    while (!cs_n && m < 100) begin
      @(negedge clk);
      m++;
    end
  endtask

  initial begin
    int n;
    int m;
    int g;
    int bad;
    int r0;
    int f0;
    int c0;
    int v0;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", tx_ready, 0);
    @(posedge clk);
    #1 chk("ready_after_rst", tx_ready, 1);

    // single byte: accept edge + CS_SETUP + 16*CLK_DIV, seen one negedge later
    resp_q.push_back(8'h3C);
    r0 = rise_cnt;
    send(8'hA5, 1'b1, 8'h3C, 1'b1);
    wait_rxv(n);
    chk("byte1_time", n, 1 + CS_SETUP + 16 * CLK_DIV);
    chk("byte1_rises", rise_cnt - r0, 8);
    wait_cs_high(m);
    chk("byte1_cs_hold", int'(m >= CS_HOLD && m <= CS_HOLD + 1), 1);
    chk("byte1_busy_off", busy, 0);

    // two bytes in one frame
    resp_q.push_back(8'h9A);
    resp_q.push_back(8'h5E);
    r0 = rise_cnt; f0 = cs_fall_cnt; c0 = cs_rise_cnt; v0 = rxv_cnt;
    send(8'h12, 1'b0, 8'h9A, 1'b1);
    wait_rxv(n);
    chk("pair1_time", n, 1 + CS_SETUP + 16 * CLK_DIV);
    g = 0; bad = 0;
    while (!tx_ready && g < 100) begin
      if (sclk || cs_n) bad++;
      @(negedge clk);
      g++;
    end
    chk("gap_len", g, GAP_EXP);
    chk("gap_lines", bad, 0);
    send(8'h34, 1'b1, 8'h5E, 1'b1);
    wait_rxv(n);
    chk("pair2_no_setup", n, 1 + 16 * CLK_DIV);
    wait_cs_high(m);
    @(negedge clk);
    chk("pair_rises", rise_cnt - r0, 16);
    chk("pair_cs_falls", cs_fall_cnt - f0, 1);
    chk("pair_cs_rises", cs_rise_cnt - c0, 1);
    chk("pair_rx_pulses", rxv_cnt - v0, 2);

    // host stalls inside BYTE_DONE
    resp_q.push_back(8'hAA);
    resp_q.push_back(8'h0F);
    send(8'h55, 1'b0, 8'hAA, 1'b1);
    wait_rxv(n);
    m = 0;
    while (!tx_ready && m < 100) begin
      @(negedge clk);
      m++;
    end
    r0 = rise_cnt; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (sclk || cs_n || !tx_ready) bad++;
    end
    chk("bp_lines", bad, 0);
    chk("bp_no_edges", rise_cnt - r0, 0);
    send(8'hC3, 1'b1, 8'h0F, 1'b1);
    wait_rxv(n);
    chk("bp_resume_time", n, 1 + 16 * CLK_DIV);
    wait_cs_high(m);

    // abort during bit 4
    resp_q.push_back(8'h77);
    r0 = rise_cnt; v0 = rxv_cnt;
    send(8'hF0, 1'b1, 8'h77, 1'b0);
    m = 0;
    while (rise_cnt - r0 < 4 && m < 300) begin
      @(negedge clk);
      m++;
    end
    chk("abort_at_bit4", rise_cnt - r0, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_tx_ready", tx_ready, 0);
    chk("abort_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("abort_no_rx", rxv_cnt - v0, 0);
    chk("abort_rx_data", rx_data, 0);
    rst_n = 1'b1;
    resp_q.push_back(8'hE7);
    send(8'h81, 1'b1, 8'hE7, 1'b1);
    wait_rxv(n);
    chk("post_abort_time", n, 1 + CS_SETUP + 16 * CLK_DIV);
    wait_cs_high(m);

    repeat (5) @(negedge clk);
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("mosi_queue_drained", exp_mosi.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
